// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a synchronous transmit FIFO.
//               Frame = start bit, DATA_BITS data bits (LSB first), optional
//               parity bit, STOP_BITS stop bits. Frames are sent
//               back-to-back while the FIFO holds words.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_data     in   word to transmit (DATA_BITS)
//   s_valid    in   s_data valid this cycle
//   s_ready    out  FIFO can accept a word (registered)
//   tx         out  serial line, idle high (registered)
//   busy       out  frame in progress or FIFO non-empty
//   fifo_count out  words waiting in the FIFO (frame in flight excluded)
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_div   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cw    = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_div_m1    = c_cnt_w'(c_div - 1);
  localparam logic [3:0]         c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_stop_last = 4'(STOP_BITS - 1);
  localparam logic [c_cw-1:0]    c_depth     = c_cw'(FIFO_DEPTH);
  localparam logic               c_odd       = (PARITY == 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  // Elaboration-time parameter legality checks
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (c_div < 1) begin : g_bad_div
    $error("uart_tx_fifo: BAUD too high for CLK_HZ");
  end

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [c_cnt_w-1:0]   r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_busy;
  logic                 r_ready;
  logic [c_cw-1:0]      r_count;
  logic [c_cw-1:0]      w_count_nxt;
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] w_head;
  logic                 w_tick;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  assign w_tick  = (r_baud == c_div_m1);
  assign w_empty = (r_count == '0);
  assign w_push  = s_valid & r_ready;
  assign w_head  = r_mem[r_rptr];

  // --------------------------------------------------------------------------
  // Frame FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Frame FSM: next state and FIFO pop decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = c_st_start;
        end
      end
      c_st_start: begin
        if (w_tick) w_state_nxt = c_st_data;
      end
      c_st_data: begin
        if (w_tick && r_bit == c_data_last)
          w_state_nxt = (PARITY != 0) ? c_st_parity : c_st_stop;
      end
      c_st_parity: begin
        if (w_tick) w_state_nxt = c_st_stop;
      end
      c_st_stop: begin
        // Chaining straight into START keeps frames gap-free
        if (w_tick && r_bit == c_stop_last) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = c_st_start;
          end else begin
            w_state_nxt = c_st_idle;
          end
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame FSM: line level for the current state (registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    w_tx_nxt = 1'b1;
    case (r_state)
      c_st_start:  w_tx_nxt = 1'b0;
      c_st_data:   w_tx_nxt = r_shift[0];
      c_st_parity: w_tx_nxt = r_par;
      default:     w_tx_nxt = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Baud/bit counters, shift register, parity and line register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= (r_state != c_st_idle) || !w_empty;
      if (r_state == c_st_idle) begin
        r_baud <= '0;
        r_bit  <= '0;
      end else if (w_tick) begin
        r_baud <= '0;
        // bit index restarts whenever a new state begins
        r_bit  <= (w_state_nxt == r_state) ? r_bit + 4'd1 : 4'd0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (^w_head) ^ c_odd;
      end else if (r_state == c_st_data && w_tick) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FIFO
  // --------------------------------------------------------------------------
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < c_depth);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  assign s_ready    = r_ready;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Five instances cover
//               the default 8N1 frame, even/odd parity, 7-bit/2-stop frames
//               and a fast-baud instance for FIFO streaming. A scoreboard
//               queue holds accepted words; a frame monitor pops and checks
//               every tx cycle of each frame against the expected bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [8:0] s_data;
  logic       s_valid;
  logic [2:0] sel;

  logic [4:0]      vld_v;
  logic [4:0]      rdy_v;
  logic [4:0]      tx_v;
  logic [4:0]      busy_v;
  logic [4:0][4:0] cnt_v;

  logic       w_tx;
  logic       w_rdy;
  logic       w_busy;
  logic [4:0] w_cnt;

  logic [8:0] sb [$];
  int n_cmp;
  int n_err;

  assign vld_v  = s_valid ? (5'd1 << sel) : 5'd0;
  assign w_tx   = tx_v[sel];
  assign w_rdy  = rdy_v[sel];
  assign w_busy = busy_v[sel];
  assign w_cnt  = cnt_v[sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx_fifo u_i0 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[7:0]), .s_valid(vld_v[0]),
    .s_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));

  uart_tx_fifo #(.PARITY(2)) u_i1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[7:0]), .s_valid(vld_v[1]),
    .s_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));

  uart_tx_fifo #(.PARITY(1)) u_i2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[7:0]), .s_valid(vld_v[2]),
    .s_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2)) u_i3 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[6:0]), .s_valid(vld_v[3]),
    .s_ready(rdy_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));

  // CLK_HZ/BAUD chosen for a divisor of 8 so long streams stay short
  uart_tx_fifo #(.CLK_HZ(800), .BAUD(100)) u_i4 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[7:0]), .s_valid(vld_v[4]),
    .s_ready(rdy_v[4]), .tx(tx_v[4]), .busy(busy_v[4]), .fifo_count(cnt_v[4]));

  // Offer one word on the selected instance; called and returns at a negedge.
  task automatic push(input logic [8:0] d, output bit waited);
    int guard;
    waited  = 1'b0;
    guard   = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (w_rdy !== 1'b1 && guard < 5000) begin
      waited = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: s_ready=%b, required 1 within 5000 cycles", w_rdy);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 9'($urandom);
    sb.push_back(d);
  endtask

  // Monitor one frame on the selected instance, checking every cycle.
  task automatic check_frame(input int div, input int nb, input int pm,
                             input int ns, input bit first, input bit last);
    logic [8:0]  d;
    logic [12:0] bits;
    logic        p;
    logic        bad_val;
    int          total, guard, bad, bad_k;
    total = 1 + nb + ((pm != 0) ? 1 : 0) + ns;
    if (!first) begin
      n_cmp++;
      if (w_tx !== 1'b0) begin
        n_err++;
        $display("FAIL no_idle: tx=%b, required 0 right after previous stop", w_tx);
      end
    end
    guard = 0;
    while (w_tx !== 1'b0 && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 30000) begin
      n_err++;
      $display("FAIL start_timeout: tx=%b, required 0 within 30000 cycles", w_tx);
      return;
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: frame started with %0d words expected, required >= 1", sb.size());
      return;
    end
    d    = sb.pop_front();
    bits = '1;
    bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits[1+i] = d[i];
      p = p ^ d[i];
    end
    if (pm != 0) bits[1+nb] = (pm == 2) ? p : ~p;
    bad = 0; bad_k = -1; bad_val = 1'b0;
    for (int k = 0; k < total * div; k++) begin
      if (k == div / 2) begin
        n_cmp++;
        if (w_busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_mid: busy=%b, required 1", w_busy);
        end
      end
      if (w_tx !== bits[k/div]) begin
        if (bad_k < 0) begin
          bad_k = k;
          bad_val = w_tx;
        end
        bad++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL frame: data=%h, %0d bad cycles, first at cycle %0d (bit %0d) tx=%b required %b",
               d, bad, bad_k, bad_k / div, bad_val, bits[bad_k/div]);
    end
    if (last) begin
      n_cmp++;
      if (w_tx !== 1'b1 || w_busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after: tx=%b busy=%b, required tx=1 busy=0", w_tx, w_busy);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_v, rdy_v, busy_v} !== {5'h1f, 5'h00, 5'h00} || cnt_v !== '0) begin
      n_err++;
      $display("FAIL reset_state: tx=%b rdy=%b busy=%b cnt=%h, required 11111 00000 00000 0",
               tx_v, rdy_v, busy_v, cnt_v);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (rdy_v !== 5'h00) begin
      n_err++;
      $display("FAIL ready_before_edge: rdy=%b, required 00000", rdy_v);
    end
    @(negedge clk);
    n_cmp++;
    if (rdy_v !== 5'h1f) begin
      n_err++;
      $display("FAIL ready_after_edge: rdy=%b, required 11111", rdy_v);
    end
  endtask

  task automatic test_basic();
    bit w;
    int n;
    sel = 3'd0;
    push(9'h055, w);
    n_cmp++;
    if (w_cnt !== 5'd1) begin
      n_err++;
      $display("FAIL count_push: fifo_count=%0d, required 1", w_cnt);
    end
    n = 0;
    while (w_tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    // accepting edge E0, sampled just after: tx falls at E0+2
    n_cmp++;
    if (n != 2) begin
      n_err++;
      $display("FAIL latency: tx fell %0d cycles after the accept sample, required 2", n);
    end
    check_frame(868, 8, 0, 1, 1'b1, 1'b1);
  endtask

  task automatic test_parity();
    bit w;
    sel = 3'd1;
    push(9'h007, w);
    check_frame(868, 8, 2, 1, 1'b1, 1'b1);
    sel = 3'd2;
    push(9'h007, w);
    check_frame(868, 8, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_7bit_2stop();
    bit w;
    sel = 3'd3;
    push(9'h041, w);
    check_frame(868, 7, 0, 2, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int first_wait;
    sel = 3'd4;
    first_wait = -1;
    fork
      for (int i = 0; i < 20; i++) check_frame(8, 8, 0, 1, i == 0, i == 19);
      begin
        for (int j = 0; j < 20; j++) begin
          bit w;
          push(9'((j * 37 + 5) & 8'hff), w);
          if (w && first_wait < 0) first_wait = j;
          if (j >= 17) begin
            n_cmp++;
            if (w_rdy !== 1'b0) begin
              n_err++;
              $display("FAIL one_accept: word %0d s_ready=%b after accept, required 0", j, w_rdy);
            end
          end
        end
      end
    join
    n_cmp++;
    if (first_wait != 17) begin
      n_err++;
      $display("FAIL accepts_before_full: %0d accepted before s_ready fell, required 17", first_wait);
    end
  endtask

  task automatic test_push_pop();
    sel = 3'd4;
    fork
      for (int i = 0; i < 8; i++) check_frame(8, 8, 0, 1, i == 0, i == 7);
      begin
        bit w;
        int guard;
        for (int j = 0; j < 6; j++) push(9'(8'hc0 + j), w);
        n_cmp++;
        if (w_cnt !== 5'd5) begin
          n_err++;
          $display("FAIL count_fill: fifo_count=%0d, required 5", w_cnt);
        end
        guard = 0;
        while (w_cnt !== 5'd4 && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
          n_err++;
          $display("FAIL pop_timeout: fifo_count=%0d, required 4 within 200 cycles", w_cnt);
        end
        // pop edge Ep seen; next pop lands 80 cycles after Ep
        push(9'h0e1, w);
        repeat (78) @(negedge clk);
        n_cmp++;
        if (w_cnt !== 5'd5) begin
          n_err++;
          $display("FAIL count_before: fifo_count=%0d, required 5", w_cnt);
        end
        s_data  = 9'h0e2;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        sb.push_back(9'h0e2);
        n_cmp++;
        if (w_cnt !== 5'd5) begin
          n_err++;
          $display("FAIL count_push_pop: fifo_count=%0d, required 5", w_cnt);
        end
      end
    join
  endtask

  task automatic test_reset_midframe();
    bit w;
    int guard, bad;
    sel = 3'd0;
    push(9'h0a5, w);
    push(9'h03c, w);
    push(9'h096, w);
    push(9'h00f, w);
    n_cmp++;
    if (w_cnt !== 5'd3) begin
      n_err++;
      $display("FAIL count_queued: fifo_count=%0d, required 3", w_cnt);
    end
    guard = 0;
    while (w_tx !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2999) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (w_tx !== 1'b1 || w_cnt !== 5'd0 || w_busy !== 1'b0 || w_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: tx=%b cnt=%0d busy=%b rdy=%b, required 1 0 0 0",
               w_tx, w_cnt, w_busy, w_rdy);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (w_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL ready_release: s_ready=%b, required 1", w_rdy);
    end
    bad = 0;
    for (int k = 0; k < 10000; k++) begin
      if (w_tx !== 1'b1 || w_busy !== 1'b0 || w_cnt !== 5'd0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL residual_frame: %0d cycles with tx/busy/count active, required 0", bad);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    sel     = 3'd0;
    s_valid = 1'b0;
    s_data  = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_7bit_2stop();
    test_back_to_back();
    test_push_pop();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
